// File: rtl/io_pkg.sv
// Shared definitions for the CPU output-port capture path.
package io_pkg;

    localparam int unsigned IO_DATA_W = 32;

    typedef enum logic {
        CAP_LEVEL = 1'b0,
        CAP_EDGE  = 1'b1
    } cap_mode_e;

    function automatic bit is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and flush.
module io_sync_fifo
    import io_pkg::*;
#(
    parameter int unsigned DATA_W = IO_DATA_W,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A flush discards any push/pop presented in the same cycle.
    assign pop_ok  = pop  & ~empty & ~flush;
    assign push_ok = push & (~full | pop_ok) & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= push_data;
    end

    // Unreset storage is masked so the head reads zero while empty.
    assign head_data = empty ? '0 : mem[rd_ptr];
    assign count     = count_q;

endmodule

// File: rtl/io_capture_fifo.sv
// Captures CPU output-port writes into a FIFO drained over a valid/ready stream.
module io_capture_fifo
    import io_pkg::*;
#(
    parameter int unsigned DATA_W    = IO_DATA_W,
    parameter int unsigned DEPTH     = 16,
    parameter bit          EDGE_MODE = 1'b1,
    parameter int unsigned OVF_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     io_write,
    input  logic [DATA_W-1:0]        io_data,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [OVF_W-1:0]         overflow
);

    logic prev_write;
    logic cap;
    logic pop;
    logic full;
    logic empty;
    logic drop;

    always_ff @(posedge clk) begin
        if (rst) prev_write <= 1'b0;
        else     prev_write <= io_write;
    end

    assign cap = (cap_mode_e'(EDGE_MODE) == CAP_EDGE) ? (io_write & ~prev_write) : io_write;
    assign pop = out_valid & out_ready;

    io_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (cap),
        .push_data (io_data),
        .pop       (pop),
        .head_data (out_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign out_valid = ~empty;

    // A capture is lost only when full with no simultaneous pop; flushed captures are not losses.
    assign drop = cap & full & ~pop & ~flush;

    always_ff @(posedge clk) begin
        if (rst)                         overflow <= '0;
        else if (drop && overflow != '1) overflow <= overflow + OVF_W'(1);
    end

endmodule

// File: tb/tb_io_capture_fifo.sv
// Directed self-checking bench for io_capture_fifo across edge/level/saturation configurations.
module tb_io_capture_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // u_e: edge mode, DEPTH=4, OVF_W=8
    logic        w_e = 0, f_e = 0, r_e = 0;
    logic [31:0] d_e = 0;
    logic        v_e;
    logic [31:0] q_e;
    logic [2:0]  c_e;
    logic [7:0]  o_e;

    // u_l: level mode, DEPTH=16
    logic        w_l = 0, f_l = 0, r_l = 0;
    logic [31:0] d_l = 0;
    logic        v_l;
    logic [31:0] q_l;
    logic [4:0]  c_l;
    logic [7:0]  o_l;

    // u_s: edge mode, DEPTH=4, OVF_W=2
    logic        w_s = 0, f_s = 0, r_s = 0;
    logic [31:0] d_s = 0;
    logic        v_s;
    logic [31:0] q_s;
    logic [2:0]  c_s;
    logic [1:0]  o_s;

    io_capture_fifo #(.DATA_W(32), .DEPTH(4), .EDGE_MODE(1'b1), .OVF_W(8)) u_e (
        .clk(clk), .rst(rst), .io_write(w_e), .io_data(d_e), .flush(f_e),
        .out_valid(v_e), .out_data(q_e), .out_ready(r_e), .count(c_e), .overflow(o_e));

    io_capture_fifo #(.DATA_W(32), .DEPTH(16), .EDGE_MODE(1'b0), .OVF_W(8)) u_l (
        .clk(clk), .rst(rst), .io_write(w_l), .io_data(d_l), .flush(f_l),
        .out_valid(v_l), .out_data(q_l), .out_ready(r_l), .count(c_l), .overflow(o_l));

    io_capture_fifo #(.DATA_W(32), .DEPTH(4), .EDGE_MODE(1'b1), .OVF_W(2)) u_s (
        .clk(clk), .rst(rst), .io_write(w_s), .io_data(d_s), .flush(f_s),
        .out_valid(v_s), .out_data(q_s), .out_ready(r_s), .count(c_s), .overflow(o_s));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_q [$];

        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_count_e", 32'(c_e), 0);
        check("rst_valid_e", 32'(v_e), 0);
        check("rst_ovf_e",   32'(o_e), 0);
        check("rst_data_e",  q_e,      0);
        check("rst_count_l", 32'(c_l), 0);

        // Empty + ready: no effect
        r_e = 1; tick();
        check("empty_pop_count", 32'(c_e), 0);
        r_e = 0;

        // Test 1: held write, edge mode -> single entry
        w_e = 1; d_e = 42; tick();
        check("t1_data",  q_e,      42);
        check("t1_valid", 32'(v_e), 1);
        tick(); tick(); tick(); tick();
        check("t1_count", 32'(c_e), 1);
        w_e = 0; r_e = 1; tick();
        check("t1_drained", 32'(c_e), 0);
        r_e = 0;

        // Test 2: level mode, 1..5 per cycle
        w_l = 1;
        for (int i = 1; i <= 5; i++) begin
            d_l = 32'(i); tick();
        end
        w_l = 0;
        check("t2_count", 32'(c_l), 5);
        r_l = 1;
        for (int i = 1; i <= 5; i++) begin
            check("t2_order", q_l, 32'(i));
            tick();
        end
        r_l = 0;
        check("t2_empty", 32'(c_l), 0);

        // Test 3: six edge captures into DEPTH=4 with no drain
        for (int i = 1; i <= 6; i++) begin
            w_e = 1; d_e = 32'(i * 10); tick();
            w_e = 0; tick();
        end
        check("t3_count", 32'(c_e), 4);
        check("t3_ovf",   32'(o_e), 2);
        check("t3_head",  q_e,      10);

        // Test 4: full + capture + pop in the same cycle
        w_e = 1; d_e = 99; r_e = 1; tick();
        check("t4_count", 32'(c_e), 4);
        check("t4_ovf",   32'(o_e), 2);
        w_e = 0;
        exp_q = '{32'd20, 32'd30, 32'd40, 32'd99};
        foreach (exp_q[k]) begin
            check("t4_drain", q_e, exp_q[k]);
            tick();
        end
        r_e = 0;
        check("t4_empty", 32'(v_e), 0);

        // Reset clears overflow before the wrap test
        rst = 1; tick(); rst = 0;
        check("rst2_ovf", 32'(o_e), 0);

        // Test 5: wrap over 3*DEPTH captures with ready held high
        r_e = 1;
        for (int i = 0; i < 12; i++) begin
            w_e = 1; d_e = 32'(100 + i); tick();
            check("t5_data", q_e, 32'(100 + i));
            w_e = 0; tick();
        end
        check("t5_count", 32'(c_e), 0);
        check("t5_ovf",   32'(o_e), 0);
        r_e = 0;

        // Test 6: five drops, then flush with count=3, then reset
        for (int i = 0; i < 9; i++) begin
            w_e = 1; d_e = 32'(200 + i); tick();
            w_e = 0; tick();
        end
        check("t6_full_count", 32'(c_e), 4);
        check("t6_ovf5",       32'(o_e), 5);
        r_e = 1; tick(); r_e = 0;
        check("t6_count3", 32'(c_e), 3);
        f_e = 1; w_e = 1; d_e = 77; r_e = 1; tick();
        f_e = 0; w_e = 0; r_e = 0;
        check("t6_flush_count", 32'(c_e), 0);
        check("t6_flush_valid", 32'(v_e), 0);
        check("t6_flush_ovf",   32'(o_e), 5);
        tick();
        w_e = 1; d_e = 88; tick();
        w_e = 0;
        check("t6_post_flush_data",  q_e,      88);
        check("t6_post_flush_count", 32'(c_e), 1);
        rst = 1; tick(); rst = 0;
        check("t6_rst_count", 32'(c_e), 0);
        check("t6_rst_ovf",   32'(o_e), 0);
        check("t6_rst_valid", 32'(v_e), 0);
        check("t6_rst_data",  q_e,      0);

        // Saturation: OVF_W=2, five drops
        for (int i = 0; i < 9; i++) begin
            w_s = 1; d_s = 32'(i); tick();
            w_s = 0; tick();
            if (i == 6) check("sat_ovf3_at_3_drops", 32'(o_s), 3);
        end
        check("sat_ovf",   32'(o_s), 3);
        check("sat_count", 32'(c_s), 4);
        check("sat_head",  q_s,      0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
